// File: rtl/pattern_checker.sv
// pattern_checker: checks a pattern generator stream against an incrementally predicted pixel value.
// Define PATTERN_CHECKER_FIRST_ERR_EN to add first-mismatch capture outputs.
module pattern_checker #(
    parameter int PIX_PER_LINE    = 16,
    parameter int LINES_PER_FRAME = 8,
    parameter int ERR_CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 f_sync,
    input  logic                 sync,
    input  logic [11:0]          constVal,
    input  logic [1:0]           X,
    input  logic [1:0]           Y,
    input  logic [2:0]           Mode,
    input  logic [11:0]          cnt,
    output logic                 busy,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic                 frame_done,
    output logic                 frame_pass,
`ifdef PATTERN_CHECKER_FIRST_ERR_EN
    output logic                 first_err_vld,
    output logic [7:0]           first_err_row,
    output logic [7:0]           first_err_col,
    output logic [11:0]          first_err_exp,
    output logic [11:0]          first_err_act,
`endif
    output logic                 mode_err
);
    localparam logic [1:0] IDLE = 2'd0, ACTIVE = 2'd1, LINE_WAIT = 2'd2, DONE = 2'd3;
    localparam int CW = $clog2(PIX_PER_LINE);
    localparam int RW = LINES_PER_FRAME > 1 ? $clog2(LINES_PER_FRAME) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(PIX_PER_LINE - 1);
    localparam logic [RW-1:0] R_LAST = RW'(LINES_PER_FRAME - 1);

    logic [1:0]           state_q, state_d;
    logic [CW-1:0]        c_q, c_d;
    logic [RW-1:0]        r_q, r_d;
    logic [2:0]           mode_q, mode_d;
    logic [1:0]           x_q, x_d, y_q, y_d;
    logic [11:0]          row_q, row_d, exp_q, exp_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic                 err_q, err_d, done_q, done_d, pass_q, pass_d, merr_q, merr_d;
    logic [11:0]          row_step, col_step;
    logic                 active, line_err, pix_err, new_line, r_adv;

    // row_q holds the expected value at c=0 of the current line; exp_q steps along the line
    always_comb begin
        row_step  = (mode_q == 3'd2 || mode_q == 3'd3) ? row_q + {10'b0, y_q} : (mode_q == 3'd4) ? ~row_q : row_q;
        col_step  = (mode_q == 3'd1 || mode_q == 3'd3) ? exp_q + {10'b0, x_q} : (mode_q == 3'd4) ? ~exp_q : exp_q;
        active    = state_q == ACTIVE;
        line_err  = !f_sync && active && sync;
        pix_err   = !f_sync && active && !sync && !merr_q && cnt != exp_q;
        new_line  = !f_sync && sync && (active || state_q == LINE_WAIT);
        r_adv     = new_line && r_q != R_LAST;
        err_d     = line_err || pix_err;
        state_d   = state_q;
        c_d       = c_q;
        r_d       = r_q;
        mode_d    = mode_q;
        x_d       = x_q;
        y_d       = y_q;
        row_d     = row_q;
        exp_d     = exp_q;
        done_d    = 1'b0;
        pass_d    = pass_q;
        merr_d    = merr_q;
        if (f_sync) begin
            state_d = ACTIVE;
            c_d     = '0;
            r_d     = '0;
            mode_d  = Mode;
            x_d     = X;
            y_d     = Y;
            row_d   = constVal;
            exp_d   = constVal;
            pass_d  = 1'b0;
            merr_d  = Mode > 3'd4;
        end else if (new_line) begin
            state_d = ACTIVE;
            c_d     = '0;
            r_d     = r_adv ? r_q + 1'b1 : r_q;
            row_d   = r_adv ? row_step : row_q;
            exp_d   = r_adv ? row_step : row_q;
        end else if (active) begin
            c_d     = c_q + 1'b1;
            exp_d   = col_step;
            state_d = (c_q != C_LAST) ? ACTIVE : (r_q == R_LAST) ? DONE : LINE_WAIT;
        end else if (state_q == DONE) begin
            state_d = IDLE;
            done_d  = 1'b1;
            pass_d  = err_cnt_q == '0 && !merr_q;
        end
        err_cnt_d = f_sync ? '0 : (err_d && !(&err_cnt_q)) ? err_cnt_q + 1'b1 : err_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            c_q       <= '0;
            r_q       <= '0;
            mode_q    <= '0;
            x_q       <= '0;
            y_q       <= '0;
            row_q     <= '0;
            exp_q     <= '0;
            err_cnt_q <= '0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            merr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            c_q       <= c_d;
            r_q       <= r_d;
            mode_q    <= mode_d;
            x_q       <= x_d;
            y_q       <= y_d;
            row_q     <= row_d;
            exp_q     <= exp_d;
            err_cnt_q <= err_cnt_d;
            err_q     <= err_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            merr_q    <= merr_d;
        end
    end

`ifdef PATTERN_CHECKER_FIRST_ERR_EN
    logic        fe_vld_q, fe_vld_d;
    logic [7:0]  fe_row_q, fe_row_d, fe_col_q, fe_col_d;
    logic [11:0] fe_exp_q, fe_exp_d, fe_act_q, fe_act_d;

    // a line-sync error has no pixel to report, so it records zero values
    always_comb begin
        fe_vld_d = fe_vld_q;
        fe_row_d = fe_row_q;
        fe_col_d = fe_col_q;
        fe_exp_d = fe_exp_q;
        fe_act_d = fe_act_q;
        if (f_sync) begin
            fe_vld_d = 1'b0;
            fe_row_d = '0;
            fe_col_d = '0;
            fe_exp_d = '0;
            fe_act_d = '0;
        end else if (err_d && !fe_vld_q) begin
            fe_vld_d = 1'b1;
            fe_row_d = 8'(r_q);
            fe_col_d = 8'(c_q);
            fe_exp_d = line_err ? 12'h000 : exp_q;
            fe_act_d = line_err ? 12'h000 : cnt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fe_vld_q <= 1'b0;
            fe_row_q <= '0;
            fe_col_q <= '0;
            fe_exp_q <= '0;
            fe_act_q <= '0;
        end else begin
            fe_vld_q <= fe_vld_d;
            fe_row_q <= fe_row_d;
            fe_col_q <= fe_col_d;
            fe_exp_q <= fe_exp_d;
            fe_act_q <= fe_act_d;
        end
    end

    assign first_err_vld = fe_vld_q;
    assign first_err_row = fe_row_q;
    assign first_err_col = fe_col_q;
    assign first_err_exp = fe_exp_q;
    assign first_err_act = fe_act_q;
`endif

    assign busy       = state_q != IDLE;
    assign err        = err_q;
    assign err_cnt    = err_cnt_q;
    assign frame_done = done_q;
    assign frame_pass = pass_q;
    assign mode_err   = merr_q;
endmodule
